// File: rtl/tensor_issue_arbiter_pkg.sv
// Shared defaults and helpers for the tensor issue arbiter.
package tensor_issue_arbiter_pkg;

   localparam int TC_ARB_NUM_REQ  = 2;
   localparam int TC_MAX_INFLIGHT = 4;
   localparam int TC_NUM_THREAD   = 4;
   localparam int TC_XLEN         = 32;
   localparam int TC_DATA_W       = TC_NUM_THREAD * TC_XLEN;
   localparam int TC_REGIDX_W     = 5;
   localparam int TC_REGEXT_W     = 1;
   localparam int TC_RIDX_W       = TC_REGIDX_W + TC_REGEXT_W;
   localparam int TC_WID_W        = 3;
   localparam int TC_RM_W         = 3;

   // Round-robin successor of idx in a ring of n requesters.
   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/tensor_issue_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requesting index at or after ptr.
module rr_arbiter #(
   parameter  int N  = 2,
   localparam int PW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [PW-1:0] grant_idx,
   output logic          grant_any
);

   // Scan the ring starting at ptr; the first hit wins.
   always_comb begin
      logic [PW:0]   sum;
      logic [PW-1:0] idx;
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      sum       = '0;
      idx       = '0;
      for (int k = 0; k < N; k++) begin
         sum = {1'b0, ptr} + (PW+1)'(k);
         if (sum >= (PW+1)'(N)) begin
            sum = sum - (PW+1)'(N);
         end
         idx = sum[PW-1:0];
         if (!grant_any && req[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = idx;
            grant_any  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tensor_issue_arbiter.sv
// Shares one tensor_core_exe between several issue ports: round-robin grant,
// per-warp busy scoreboard, in-flight credit limit and one output register.
module tensor_issue_arbiter
   import tensor_issue_arbiter_pkg::*;
#(
   parameter  int NUM_REQ      = TC_ARB_NUM_REQ,
   parameter  int MAX_INFLIGHT = TC_MAX_INFLIGHT,
   parameter  int DATA_W       = TC_DATA_W,
   parameter  int RIDX_W       = TC_RIDX_W,
   parameter  int WID_W        = TC_WID_W,
   localparam int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid_i,
   output logic [NUM_REQ-1:0]        req_ready_o,
   input  logic [NUM_REQ*DATA_W-1:0] req_in1_i,
   input  logic [NUM_REQ*DATA_W-1:0] req_in2_i,
   input  logic [NUM_REQ*DATA_W-1:0] req_in3_i,
   input  logic [NUM_REQ*RIDX_W-1:0] req_reg_idxw_i,
   input  logic [NUM_REQ*WID_W-1:0]  req_wid_i,
   input  logic [NUM_REQ*3-1:0]      req_rm_i,
   output logic [DATA_W-1:0]         exe_in1_o,
   output logic [DATA_W-1:0]         exe_in2_o,
   output logic [DATA_W-1:0]         exe_in3_o,
   output logic [RIDX_W-1:0]         exe_reg_idxw_o,
   output logic [WID_W-1:0]          exe_wid_o,
   output logic [2:0]                exe_rm_o,
   output logic                      exe_valid_o,
   input  logic                      exe_ready_i,
   input  logic                      wb_valid_i,
   input  logic                      wb_ready_i,
   input  logic [WID_W-1:0]          wb_wid_i,
   output logic [CNT_W-1:0]          inflight_o,
   output logic                      idle_o
);

   localparam int PTR_W    = $clog2(NUM_REQ);
   localparam int NUM_WARP = 1 << WID_W;

   logic [PTR_W-1:0]    ptr_reg, ptr_next;
   logic [NUM_WARP-1:0] busy_reg, busy_next;
   logic [CNT_W-1:0]    inflight_reg, inflight_next;

   logic                exe_valid_reg;
   logic [DATA_W-1:0]   exe_in1_reg, exe_in2_reg, exe_in3_reg;
   logic [RIDX_W-1:0]   exe_ridx_reg;
   logic [WID_W-1:0]    exe_wid_reg;
   logic [2:0]          exe_rm_reg;

   logic [NUM_REQ-1:0]  eligible, grant;
   logic [PTR_W-1:0]    grant_idx;
   logic                grant_any;
   logic                issue_en, accept, complete;
   logic [WID_W-1:0]    sel_wid;

   // A requester is eligible only if its warp has nothing in flight (registered busy, no bypass).
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_elig
         assign eligible[gi] = req_valid_i[gi] & ~busy_reg[req_wid_i[gi*WID_W +: WID_W]];
      end
   endgenerate

   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .req       (eligible),
      .ptr       (ptr_reg),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_any (grant_any)
   );

   assign issue_en    = ~rst & (~exe_valid_reg | exe_ready_i) &
                        (inflight_reg < CNT_W'(MAX_INFLIGHT));
   assign req_ready_o = issue_en ? grant : '0;
   assign accept      = issue_en & grant_any;
   assign complete    = wb_valid_i & wb_ready_i;
   assign sel_wid     = req_wid_i[int'(grant_idx)*WID_W +: WID_W];

   // Next-state for pointer, scoreboard and credit counter; a clear is applied before a set.
   always_comb begin
      ptr_next      = ptr_reg;
      busy_next     = busy_reg;
      inflight_next = inflight_reg;
      if (accept) begin
         ptr_next = PTR_W'(rr_next(int'(grant_idx), NUM_REQ));
      end
      if (complete) begin
         busy_next[wb_wid_i] = 1'b0;
      end
      if (accept) begin
         busy_next[sel_wid] = 1'b1;
      end
      case ({accept, complete})
         2'b10:   inflight_next = inflight_reg + 1'b1;
         2'b01:   inflight_next = (inflight_reg != '0) ? inflight_reg - 1'b1 : '0;
         default: inflight_next = inflight_reg;
      endcase
   end

   // Arbitration and tracking state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_reg      <= '0;
         busy_reg     <= '0;
         inflight_reg <= '0;
      end else begin
         ptr_reg      <= ptr_next;
         busy_reg     <= busy_next;
         inflight_reg <= inflight_next;
      end
   end

   // Output stage: load on accept, empty on drain, otherwise hold stable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exe_valid_reg <= 1'b0;
         exe_in1_reg   <= '0;
         exe_in2_reg   <= '0;
         exe_in3_reg   <= '0;
         exe_ridx_reg  <= '0;
         exe_wid_reg   <= '0;
         exe_rm_reg    <= '0;
      end else if (accept) begin
         exe_valid_reg <= 1'b1;
         exe_in1_reg   <= req_in1_i[int'(grant_idx)*DATA_W +: DATA_W];
         exe_in2_reg   <= req_in2_i[int'(grant_idx)*DATA_W +: DATA_W];
         exe_in3_reg   <= req_in3_i[int'(grant_idx)*DATA_W +: DATA_W];
         exe_ridx_reg  <= req_reg_idxw_i[int'(grant_idx)*RIDX_W +: RIDX_W];
         exe_wid_reg   <= sel_wid;
         exe_rm_reg    <= req_rm_i[int'(grant_idx)*3 +: 3];
      end else if (exe_ready_i) begin
         exe_valid_reg <= 1'b0;
      end
   end

   // A writeback with nothing in flight means the downstream unit is misbehaving.
   assert property (@(posedge clk) disable iff (rst) !(complete && inflight_reg == '0));

   assign exe_valid_o    = exe_valid_reg;
   assign exe_in1_o      = exe_in1_reg;
   assign exe_in2_o      = exe_in2_reg;
   assign exe_in3_o      = exe_in3_reg;
   assign exe_reg_idxw_o = exe_ridx_reg;
   assign exe_wid_o      = exe_wid_reg;
   assign exe_rm_o       = exe_rm_reg;
   assign inflight_o     = inflight_reg;
   assign idle_o         = (inflight_reg == '0) & ~exe_valid_reg;

endmodule

// File: tb/tb_tensor_issue_arbiter.sv
// Scoreboard bench for tensor_issue_arbiter: accepted ops are queued and
// compared when the output stage hands them to the execution unit.
module tb_tensor_issue_arbiter;

   localparam int NR = 2;
   localparam int MI = 4;
   localparam int DW = 16;
   localparam int RW = 6;
   localparam int WW = 3;
   localparam int CW = $clog2(MI + 1);

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [NR-1:0]    req_valid;
   logic [NR-1:0]    req_ready;
   logic [NR*DW-1:0] req_in1, req_in2, req_in3;
   logic [NR*RW-1:0] req_ridx;
   logic [NR*WW-1:0] req_wid;
   logic [NR*3-1:0]  req_rm;
   logic [DW-1:0]    exe_in1, exe_in2, exe_in3;
   logic [RW-1:0]    exe_ridx;
   logic [WW-1:0]    exe_wid;
   logic [2:0]       exe_rm;
   logic             exe_valid, exe_ready;
   logic             wb_valid, wb_ready;
   logic [WW-1:0]    wb_wid;
   logic [CW-1:0]    inflight;
   logic             idle;

   typedef struct packed {
      logic [DW-1:0] in1;
      logic [DW-1:0] in2;
      logic [DW-1:0] in3;
      logic [RW-1:0] ridx;
      logic [WW-1:0] wid;
      logic [2:0]    rm;
   } op_t;

   op_t  exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   logic fire_prev = 1'b0;
   op_t  held_op;

   always #5 clk = ~clk;

   tensor_issue_arbiter #(
      .NUM_REQ(NR), .MAX_INFLIGHT(MI), .DATA_W(DW), .RIDX_W(RW), .WID_W(WW)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_in1_i(req_in1), .req_in2_i(req_in2), .req_in3_i(req_in3),
      .req_reg_idxw_i(req_ridx), .req_wid_i(req_wid), .req_rm_i(req_rm),
      .exe_in1_o(exe_in1), .exe_in2_o(exe_in2), .exe_in3_o(exe_in3),
      .exe_reg_idxw_o(exe_ridx), .exe_wid_o(exe_wid), .exe_rm_o(exe_rm),
      .exe_valid_o(exe_valid), .exe_ready_i(exe_ready),
      .wb_valid_i(wb_valid), .wb_ready_i(wb_ready), .wb_wid_i(wb_wid),
      .inflight_o(inflight), .idle_o(idle)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic op_t get_op(input int i);
      op_t o;
      o.in1  = req_in1[i*DW +: DW];
      o.in2  = req_in2[i*DW +: DW];
      o.in3  = req_in3[i*DW +: DW];
      o.ridx = req_ridx[i*RW +: RW];
      o.wid  = req_wid[i*WW +: WW];
      o.rm   = req_rm[i*3 +: 3];
      return o;
   endfunction

   task automatic set_req(input int i, input logic v, input logic [WW-1:0] w);
      req_valid[i]         = v;
      req_in1[i*DW +: DW]  = DW'($urandom);
      req_in2[i*DW +: DW]  = DW'($urandom);
      req_in3[i*DW +: DW]  = DW'($urandom);
      req_ridx[i*RW +: RW] = RW'($urandom);
      req_wid[i*WW +: WW]  = w;
      req_rm[i*3 +: 3]     = 3'($urandom);
   endtask

   task automatic set_wb(input logic v, input logic [WW-1:0] w);
      wb_valid = v;
      wb_ready = v;
      wb_wid   = w;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: pop on hand-off to the execution unit, push on accept.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         fire_prev = 1'b0;
      end else begin
         op_t e;
         if (fire_prev) check_eq("exe_valid_latency", 64'(exe_valid), 64'd1);
         check_eq("ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
         if (exe_valid && exe_ready) begin
            if (exp_q.size() == 0) begin
               check_eq("sb_underflow", 64'(exp_q.size()), 64'd1);
            end else begin
               e = exp_q.pop_front();
               $display("[TB] exe op wid=%0d ridx=%0d in1=0x%0h", exe_wid, exe_ridx, exe_in1);
               check_eq("sb_in1",  64'(exe_in1),  64'(e.in1));
               check_eq("sb_in2",  64'(exe_in2),  64'(e.in2));
               check_eq("sb_in3",  64'(exe_in3),  64'(e.in3));
               check_eq("sb_ridx", 64'(exe_ridx), 64'(e.ridx));
               check_eq("sb_wid",  64'(exe_wid),  64'(e.wid));
               check_eq("sb_rm",   64'(exe_rm),   64'(e.rm));
            end
         end
         fire_prev = |(req_valid & req_ready);
         for (int i = 0; i < NR; i++) begin
            if (req_valid[i] && req_ready[i]) exp_q.push_back(get_op(i));
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      req_valid = '0; req_in1 = '0; req_in2 = '0; req_in3 = '0;
      req_ridx = '0; req_wid = '0; req_rm = '0;
      exe_ready = 1'b1;
      set_wb(1'b0, '0);

      // Reset state, with requests already pending.
      set_req(0, 1'b1, 3'd0);
      set_req(1, 1'b1, 3'd1);
      repeat (2) @(negedge clk);
      check_eq("rst_exe_valid", 64'(exe_valid), 64'd0);
      check_eq("rst_ready",     64'(req_ready), 64'd0);
      check_eq("rst_inflight",  64'(inflight),  64'd0);
      check_eq("rst_idle",      64'(idle),      64'd1);
      check_eq("rst_payload",   64'(exe_in1),   64'd0);
      step();
      rst = 1'b0;

      // Round-robin 0,1,0,1 with each warp completing the cycle after issue.
      @(negedge clk); check_eq("t2_grant_a", 64'(req_ready), 64'b01);
      step(); set_req(0, 1'b1, 3'd0); set_req(1, 1'b1, 3'd1); set_wb(1'b1, 3'd0);
      @(negedge clk); check_eq("t2_grant_b", 64'(req_ready), 64'b10);
      step(); set_req(0, 1'b1, 3'd0); set_req(1, 1'b1, 3'd1); set_wb(1'b1, 3'd1);
      @(negedge clk); check_eq("t2_grant_c", 64'(req_ready), 64'b01);
      step(); set_req(0, 1'b1, 3'd0); set_req(1, 1'b1, 3'd1); set_wb(1'b1, 3'd0);
      @(negedge clk); check_eq("t2_grant_d", 64'(req_ready), 64'b10);
      check_eq("t2_inflight_steady", 64'(inflight), 64'd1);
      step(); req_valid = '0; set_wb(1'b1, 3'd1);
      @(negedge clk); check_eq("t2_last_valid", 64'(exe_valid), 64'd1);
      step(); set_wb(1'b0, '0);
      @(negedge clk);
      check_eq("t2_inflight_zero", 64'(inflight), 64'd0);
      check_eq("t2_idle",          64'(idle),     64'd1);

      // Busy warp is blocked until its writeback, then eligible the next cycle.
      step(); set_req(0, 1'b1, 3'd3);
      @(negedge clk); check_eq("t3_first", 64'(req_ready), 64'b01);
      step(); set_req(0, 1'b1, 3'd3);
      @(negedge clk); check_eq("t3_busy_a", 64'(req_ready), 64'b00);
      step();
      @(negedge clk); check_eq("t3_busy_b", 64'(req_ready), 64'b00);
      step(); set_wb(1'b1, 3'd3);
      @(negedge clk); check_eq("t3_no_bypass", 64'(req_ready), 64'b00);
      step(); set_wb(1'b0, '0);
      @(negedge clk); check_eq("t3_after_wb", 64'(req_ready), 64'b01);
      step(); req_valid = '0; set_wb(1'b1, 3'd3);
      step(); set_wb(1'b0, '0);

      // Credit limit: four warps in flight hold off the fifth until one completes.
      for (int w = 4; w < 8; w++) begin
         set_req(0, 1'b1, WW'(w));
         @(negedge clk); check_eq("t4_fill", 64'(req_ready), 64'b01);
         step();
      end
      set_req(0, 1'b1, 3'd0);
      @(negedge clk);
      check_eq("t4_full",          64'(req_ready), 64'b00);
      check_eq("t4_full_inflight", 64'(inflight),  64'd4);
      check_eq("t4_full_idle",     64'(idle),      64'd0);
      step();
      @(negedge clk); check_eq("t4_full_hold", 64'(req_ready), 64'b00);
      step(); set_wb(1'b1, 3'd4);
      @(negedge clk); check_eq("t4_full_wb", 64'(req_ready), 64'b00);
      step(); set_wb(1'b0, '0);
      @(negedge clk);
      check_eq("t4_released_inflight", 64'(inflight),  64'd3);
      check_eq("t4_fifth",             64'(req_ready), 64'b01);
      step(); req_valid = '0;
      @(negedge clk); check_eq("t4_refilled", 64'(inflight), 64'd4);
      for (int w = 5; w < 9; w++) begin
         step(); set_wb(1'b1, WW'(w % 8));
      end
      step(); set_wb(1'b0, '0);
      @(negedge clk); check_eq("t4_drained", 64'(inflight), 64'd0);

      // Back-pressure: payload holds while stalled, then drain and accept together.
      step(); exe_ready = 1'b0; set_req(0, 1'b1, 3'd1);
      held_op = get_op(0);
      @(negedge clk); check_eq("t5_first", 64'(req_ready), 64'b01);
      step(); set_req(0, 1'b1, 3'd2);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check_eq("t5_stall_ready", 64'(req_ready), 64'b00);
         check_eq("t5_stall_valid", 64'(exe_valid), 64'd1);
         check_eq("t5_stall_in1",   64'(exe_in1),   64'(held_op.in1));
         check_eq("t5_stall_wid",   64'(exe_wid),   64'(held_op.wid));
         step();
      end
      exe_ready = 1'b1;
      @(negedge clk); check_eq("t5_drain_accept", 64'(req_ready), 64'b01);
      step(); req_valid = '0;
      @(negedge clk);
      check_eq("t5_next_valid", 64'(exe_valid), 64'd1);
      check_eq("t5_next_wid",   64'(exe_wid),   64'd2);
      step();
      @(negedge clk); check_eq("t5_empty", 64'(exe_valid), 64'd0);
      step(); set_wb(1'b1, 3'd1);
      step(); set_wb(1'b1, 3'd2);
      step(); set_wb(1'b0, '0);

      // Accept and completion in the same cycle leave the count unchanged.
      set_req(0, 1'b1, 3'd3);
      @(negedge clk); check_eq("t6_acc_a", 64'(req_ready), 64'b01);
      step(); set_req(0, 1'b1, 3'd4);
      @(negedge clk); check_eq("t6_acc_b", 64'(req_ready), 64'b01);
      step(); set_req(0, 1'b1, 3'd5); set_wb(1'b1, 3'd3);
      @(negedge clk);
      check_eq("t6_pre_inflight", 64'(inflight),  64'd2);
      check_eq("t6_acc_c",        64'(req_ready), 64'b01);
      step(); req_valid = '0; set_wb(1'b0, '0);
      @(negedge clk); check_eq("t6_inflight_hold", 64'(inflight), 64'd2);
      step(); set_wb(1'b1, 3'd4);
      step(); set_wb(1'b1, 3'd5);
      step(); set_wb(1'b0, '0);

      // Asynchronous reset with an op stalled in the output stage.
      set_req(0, 1'b1, 3'd6);
      @(negedge clk); check_eq("t1_setup", 64'(req_ready), 64'b01);
      step(); req_valid = '0; exe_ready = 1'b0;
      #2 rst = 1'b1;
      #1;
      check_eq("t1_async_valid",    64'(exe_valid), 64'd0);
      check_eq("t1_async_inflight", 64'(inflight),  64'd0);
      check_eq("t1_async_idle",     64'(idle),      64'd1);
      step(); step();
      rst = 1'b0; exe_ready = 1'b1;
      set_req(0, 1'b1, 3'd6); set_req(1, 1'b1, 3'd6);
      @(negedge clk); check_eq("t1_ptr_busy_cleared", 64'(req_ready), 64'b01);
      step(); req_valid = '0;
      @(negedge clk); check_eq("t1_resume_valid", 64'(exe_valid), 64'd1);
      step(); set_wb(1'b1, 3'd6);
      step(); set_wb(1'b0, '0);
      @(negedge clk);
      check_eq("t1_final_inflight", 64'(inflight), 64'd0);
      check_eq("t1_final_idle",     64'(idle),     64'd1);
      check_eq("sb_empty",          64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
